// File: rtl/if_id_buffer_pkg.sv
// Shared CPU constants for the fetch/decode boundary.
// The PC-next logic and decode use the same values.
package if_id_buffer_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;
    localparam int          SLOTS     = 2;

    typedef logic [1:0] count_t;

endpackage : if_id_buffer_pkg

// File: rtl/if_id_buffer.sv
// Two-entry in-order buffer of {PC, instruction} pairs between fetch and decode.
// InReady comes from registered state only, so it can drive the PC register enable.
module if_id_buffer #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] NOP_INSTR = DW'(if_id_buffer_pkg::NOP_INSTR)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Flush,
    input  logic          InValid,
    input  logic [DW-1:0] PCin,
    input  logic [DW-1:0] InstrIn,
    output logic          InReady,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutPC,
    output logic [DW-1:0] OutPCPlus4,
    output logic [DW-1:0] OutInstr
);
    import if_id_buffer_pkg::*;

    count_t        count_q, count_d;
    logic          head_q, head_d;
    logic [DW-1:0] slot_pc_q    [SLOTS];
    logic [DW-1:0] slot_instr_q [SLOTS];

    logic push, pop, wr_idx;

    assign InReady  = (count_q != 2'd2) & Rst_n;
    assign OutValid = (count_q != 2'd0);

    assign push = InValid & InReady & ~Flush;
    assign pop  = OutValid & OutReady & ~Flush;

    // With one entry held the free slot is the other one; when empty it is the head.
    assign wr_idx = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (Flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) head_d = ~head_q;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block with no
    // edge on Rst_n; the two slots are small enough to clear here as well.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_pc_q[i]    <= '0;
                slot_instr_q[i] <= NOP_INSTR;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push) begin
                slot_pc_q[wr_idx]    <= PCin;
                slot_instr_q[wr_idx] <= InstrIn;
            end
        end
    end

    assign OutPC      = OutValid ? slot_pc_q[head_q]    : '0;
    assign OutInstr   = OutValid ? slot_instr_q[head_q] : NOP_INSTR;
    assign OutPCPlus4 = OutPC + DW'(PC_STEP);

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
// Directed vector table plus a randomized reference-FIFO run for if_id_buffer.
module tb_if_id_buffer;

    logic        Clk = 1'b0;
    logic        Rst_n, Flush, InValid, OutReady;
    logic [31:0] PCin, InstrIn;
    logic        InReady, OutValid;
    logic [31:0] OutPC, OutPCPlus4, OutInstr;

    int total = 0;
    int bad   = 0;

    if_id_buffer dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Flush      (Flush),
        .InValid    (InValid),
        .PCin       (PCin),
        .InstrIn    (InstrIn),
        .InReady    (InReady),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutPC      (OutPC),
        .OutPCPlus4 (OutPCPlus4),
        .OutInstr   (OutInstr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n, flush, in_valid, out_ready;
        logic [31:0] pc, instr;
        logic        exp_in_ready, exp_out_valid;
        logic [31:0] exp_pc, exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic flush, input logic in_valid,
                       input logic out_ready, input logic [31:0] pc, input logic [31:0] instr,
                       input logic e_ir, input logic e_ov,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst_n = rst_n; v.flush = flush; v.in_valid = in_valid; v.out_ready = out_ready;
        v.pc = pc; v.instr = instr;
        v.exp_in_ready = e_ir; v.exp_out_valid = e_ov;
        v.exp_pc = e_pc; v.exp_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Outputs are compared 1 time unit after the negedge that drove the inputs.
    task automatic check_outputs(input string tag, input logic e_ir, input logic e_ov,
                                 input logic [31:0] e_pc, input logic [31:0] e_instr);
        check({tag, ".InReady"},    32'(InReady),  32'(e_ir));
        check({tag, ".OutValid"},   32'(OutValid), 32'(e_ov));
        check({tag, ".OutPC"},      OutPC,         e_pc);
        check({tag, ".OutInstr"},   OutInstr,      e_instr);
        check({tag, ".OutPCPlus4"}, OutPCPlus4,    e_pc + 32'd4);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        logic [31:0] q_pc[$];
        logic [31:0] q_in[$];
        logic [31:0] next_pc;

        Rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        PCin = '0; InstrIn = '0;
        @(posedge Clk);

        // rst flush iv or  pc            instr          ir ov exp_pc        exp_instr
        add(0, 0, 1, 0, 32'h0,         32'h2008_0001, 0, 0, 32'h0,         NOP);
        // streaming
        add(1, 0, 1, 1, 32'h0,         32'h2008_0001, 1, 0, 32'h0,         NOP);
        add(1, 0, 1, 1, 32'h4,         32'h2008_0002, 1, 1, 32'h0,         32'h2008_0001);
        add(1, 0, 1, 1, 32'h8,         32'h2008_0003, 1, 1, 32'h4,         32'h2008_0002);
        add(1, 0, 0, 1, 32'h0,         32'h0,         1, 1, 32'h8,         32'h2008_0003);
        add(1, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         NOP);
        // decode stall fills both slots, then drains in order
        add(1, 0, 1, 0, 32'h10,        32'hB000_0010, 1, 0, 32'h0,         NOP);
        add(1, 0, 1, 0, 32'h14,        32'hB000_0014, 1, 1, 32'h10,        32'hB000_0010);
        add(1, 0, 1, 0, 32'h18,        32'hB000_0018, 0, 1, 32'h10,        32'hB000_0010);
        add(1, 0, 1, 1, 32'h18,        32'hB000_0018, 0, 1, 32'h10,        32'hB000_0010);
        add(1, 0, 1, 1, 32'h18,        32'hB000_0018, 1, 1, 32'h14,        32'hB000_0014);
        add(1, 0, 0, 1, 32'h0,         32'h0,         1, 1, 32'h18,        32'hB000_0018);
        // fill, then flush with a same-cycle push
        add(1, 0, 1, 0, 32'h20,        32'hC000_0020, 1, 0, 32'h0,         NOP);
        add(1, 0, 1, 0, 32'h24,        32'hC000_0024, 1, 1, 32'h20,        32'hC000_0020);
        add(1, 1, 1, 1, 32'h28,        32'hC000_0028, 0, 1, 32'h20,        32'hC000_0020);
        add(1, 0, 1, 0, 32'h40,        32'hD000_0040, 1, 0, 32'h0,         NOP);
        add(1, 0, 0, 1, 32'h0,         32'h0,         1, 1, 32'h40,        32'hD000_0040);
        // PC wrap, then reset with two entries held
        add(1, 0, 1, 0, 32'hFFFF_FFFC, 32'hE000_0001, 1, 0, 32'h0,         NOP);
        add(1, 0, 1, 0, 32'h0,         32'hE000_0002, 1, 1, 32'hFFFF_FFFC, 32'hE000_0001);
        add(0, 0, 1, 0, 32'h8,         32'hE000_0003, 0, 1, 32'hFFFF_FFFC, 32'hE000_0001);
        add(1, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         NOP);
        // reset and flush together
        add(1, 0, 1, 0, 32'h50,        32'hF000_0050, 1, 0, 32'h0,         NOP);
        add(0, 1, 1, 1, 32'h54,        32'hF000_0054, 0, 1, 32'h50,        32'hF000_0050);
        add(1, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         NOP);

        foreach (vecs[i]) begin
            @(negedge Clk);
            Rst_n    = vecs[i].rst_n;
            Flush    = vecs[i].flush;
            InValid  = vecs[i].in_valid;
            OutReady = vecs[i].out_ready;
            PCin     = vecs[i].pc;
            InstrIn  = vecs[i].instr;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                          vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Randomized handshake against a reference FIFO; the DUT is empty here.
        next_pc = 32'h1000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic m_ready, m_push, m_pop;
            @(negedge Clk);
            Rst_n    = 1'b1;
            Flush    = ($urandom_range(0, 63) == 0);
            InValid  = $urandom_range(0, 1);
            OutReady = $urandom_range(0, 1);
            PCin     = next_pc;
            InstrIn  = $urandom;
            #1;
            m_ready = (q_pc.size() < 2);
            if (q_pc.size() != 0)
                check_outputs($sformatf("rnd%0d", cyc), m_ready, 1'b1, q_pc[0], q_in[0]);
            else
                check_outputs($sformatf("rnd%0d", cyc), m_ready, 1'b0, 32'h0, NOP);
            m_push = InValid & m_ready & ~Flush;
            m_pop  = (q_pc.size() != 0) & OutReady & ~Flush;
            if (Flush) begin
                q_pc.delete();
                q_in.delete();
                next_pc = next_pc + 32'h100;
            end else begin
                if (m_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (m_push) begin
                    q_pc.push_back(PCin);
                    q_in.push_back(InstrIn);
                    next_pc = next_pc + 32'd4;
                end
            end
        end

        @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_buffer

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry fetch buffer between the fetch stage (program counter register plus instruction memory) and the decode stage. It captures each fetched {PC, instruction} pair with a valid/ready handshake and presents them in order to decode. Its `InReady` output drives the program counter's `EN`, so the PC advances only when a fetch is accepted. `Flush` discards wrong-path instructions on branch/jump redirect.

## Interface
- `DW`, default 32: PC and instruction width.
- `NOP_INSTR`, default 32'h00000000: instruction presented on `OutInstr` when empty or after reset/flush.
- `Clk`, input, 1: clock. Storage updates on posedge; the PC register updates on negedge, so `PCin`/`InstrIn` are stable at posedge.
- `Rst_n`, input, 1: reset. Synchronous, active-low.
- `Flush`, input, 1: discard all buffered entries and any same-cycle push.
- `InValid`, input, 1: fetch presents a valid pair.
- `PCin`, input, DW: PC of the fetched instruction.
- `InstrIn`, input, DW: fetched instruction word.
- `InReady`, output, 1: buffer accepts this cycle; wired to the PC register's `EN`.
- `OutValid`, output, 1: head entry valid.
- `OutReady`, input, 1: decode consumes the head this cycle (0 = decode stall).
- `OutPC`, output, DW: PC of the head entry.
- `OutPCPlus4`, output, DW: `OutPC` + 4, for link-register writes.
- `OutInstr`, output, DW: instruction of the head entry.

## Operation
- State: 2 entry slots, head pointer (1 bit), occupancy count 0..2.
- push = `InValid & InReady & !Flush`; pop = `OutValid & OutReady & !Flush`.
- `InReady` = (count != 2) & `Rst_n`. Derived from registered state only; there is no combinational path from `OutReady`.
- `OutValid` = (count != 0). `OutPC`/`OutInstr` come from the head slot when valid. When empty they are 0 and `NOP_INSTR`.
- count = 0: a push writes the head slot; count becomes 1.
- count = 1: push+pop writes the free slot and advances the head; count stays 1. Push only gives count 2. Pop only gives count 0.
- count = 2: no push possible. Pop advances the head; count becomes 1.
- `Flush` takes priority over push and pop. Next cycle count = 0 and `OutValid` = 0. The same-cycle `InValid` pair is dropped.
- Order is strictly FIFO. An entry is never duplicated or lost except by `Flush`.
- `OutPCPlus4` is computed mod 2^DW, so 32'hFFFFFFFC gives 32'h00000000.
- Reset (`Rst_n`=0 at posedge): count 0, head 0, slots cleared. `OutValid`=0, `OutPC`=0, `OutPCPlus4`=4, `OutInstr`=`NOP_INSTR`. `InReady`=0 while `Rst_n` is low. Reset asserted mid-operation discards all entries exactly as a flush does.

## Timing
- Latency: a pair pushed at posedge N appears on `Out*` with `OutValid`=1 after posedge N (visible in cycle N+1).
- Throughput: 1 pair/cycle with `OutReady` held 1.
- Decode stall: up to 2 pairs are absorbed. `InReady` falls the cycle after count reaches 2, freezing the PC at the next negedge.
- `InReady` rises the cycle after the first pop from full.
- `Flush` at posedge N gives `OutValid`=0 and `InReady`=1 in cycle N+1. The redirected PC is accepted from cycle N+1.
- `Flush` and `Rst_n`=0 in the same cycle: reset values apply.

## Structure
- Shared CPU package holds `NOP_INSTR` and `PC_STEP` (=4), reused by the PC-next logic and decode.
- No sub-module. The two slots are an internal register array in this module.

## Test plan
- Reset → `OutValid`=0, `OutInstr`=32'h00000000, `OutPC`=0, `OutPCPlus4`=4. `InReady`=0 while `Rst_n`=0, 1 in the first cycle after release.
- Streaming: push PC 0,4,8 with instrs 32'h20080001.. and `OutReady`=1 → each appears 1 cycle later, in order; `OutPCPlus4`=4,8,12.
- Stall: `OutReady`=0, push PC 0x10 and 0x14 → count 2, `InReady`=0, PC 0x18 held. Release → 0x10, 0x14, 0x18 out with no loss or duplicate.
- Flush with count=2 and `InValid`=1 → next cycle `OutValid`=0, `InReady`=1. Push target PC 0x40 → `OutPC`=0x40 next cycle.
- Simultaneous push+pop at count=1 → count stays 1 and the head becomes the new pair. Randomized `InValid`/`OutReady` over 10k cycles matches a reference FIFO model.
- Wrap: push PC 32'hFFFFFFFC → `OutPCPlus4`=32'h00000000. `Rst_n`=0 with count=2 → cleared next cycle.
